// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between requesters A and B.
// Contains the 8-bit ALU (alu_always) and the scheduler top (alu_sched).

module alu_always (
  input  logic [3:0] ctrl,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] out,
  output logic       carry,
  output logic       err
);

  logic [8:0] wide;

  always_comb begin
    out   = 8'h00;
    carry = 1'b0;
    err   = 1'b0;
    wide  = 9'h000;
    case (ctrl)
      4'd0: begin
        wide  = {1'b0, x} + {1'b0, y};
        out   = wide[7:0];
        carry = wide[8];
      end
      4'd1: begin
        wide  = {1'b0, x} - {1'b0, y};
        out   = wide[7:0];
        carry = wide[8];
      end
      4'd2: out = x & y;
      4'd3: out = x | y;
      4'd4: out = ~x;
      4'd5: out = x ^ y;
      4'd6: out = ~(x | y);
      4'd7: out = y << x[2:0];
      4'd8: out = y >> x[2:0];
      4'd9: out = {x[7], x[7:1]};
      default: err = 1'b1;
    endcase
  end

endmodule

module alu_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [3:0] a_ctrl,
  input  logic [7:0] a_x,
  input  logic [7:0] a_y,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [3:0] b_ctrl,
  input  logic [7:0] b_x,
  input  logic [7:0] b_y,
  output logic       r_valid,
  input  logic       r_ready,
  output logic [7:0] r_out,
  output logic       r_carry,
  output logic       r_src,
  output logic       r_err,
  output logic [7:0] r_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] op_ctrl;
  logic [7:0] op_x, op_y;
  logic       op_src;
  logic       last_grant;
  logic       grant_a, grant_b, window, accept, take;
  logic [7:0] alu_out;
  logic       alu_carry, alu_err;

  alu_always u_alu (
    .ctrl  (op_ctrl),
    .x     (op_x),
    .y     (op_y),
    .out   (alu_out),
    .carry (alu_carry),
    .err   (alu_err)
  );

  // Arbitration, accept window and next-state decode
  always_comb begin
    state_next = state;
    grant_b    = b_valid & (~a_valid | ~last_grant);
    grant_a    = a_valid & ~grant_b;
    window     = (state == IDLE) | ((state == RESP) & r_ready);
    a_ready    = window & grant_a;
    b_ready    = window & grant_b;
    accept     = a_ready | b_ready;
    take       = (state == RESP) & r_ready;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (r_ready) state_next = accept ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // last_grant: 0 = A, 1 = B; resets to B so A wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_ctrl    <= 4'd0;
      op_x       <= 8'h00;
      op_y       <= 8'h00;
      op_src     <= 1'b0;
      last_grant <= 1'b1;
      r_valid    <= 1'b0;
      r_out      <= 8'h00;
      r_carry    <= 1'b0;
      r_src      <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= 8'h00;
    end else begin
      if (accept) begin
        op_ctrl    <= b_ready ? b_ctrl : a_ctrl;
        op_x       <= b_ready ? b_x : a_x;
        op_y       <= b_ready ? b_y : a_y;
        op_src     <= b_ready;
        last_grant <= b_ready;
      end
      if (state == EXEC) begin
        r_out   <= alu_out;
        r_carry <= alu_carry;
        r_src   <= op_src;
        r_err   <= alu_err;
      end
      r_valid <= (state_next == RESP);
      if (take) r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed cases plus randomized traffic
// checked against an arithmetic reference model and a result queue.

module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [3:0] a_ctrl, b_ctrl;
  logic [7:0] a_x, a_y, b_x, b_y;
  logic       r_valid, r_ready, r_carry, r_src, r_err;
  logic [7:0] r_out, r_count;

  int   checks = 0;
  int   errors = 0;
  logic exp_last_b;

  alu_sched dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_ctrl(a_ctrl), .a_x(a_x), .a_y(a_y),
    .b_valid(b_valid), .b_ready(b_ready), .b_ctrl(b_ctrl), .b_x(b_x), .b_y(b_y),
    .r_valid(r_valid), .r_ready(r_ready), .r_out(r_out), .r_carry(r_carry),
    .r_src(r_src), .r_err(r_err), .r_count(r_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference ALU: returns {err, carry, out} from plain integer arithmetic
  function automatic logic [9:0] ref_alu(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    int s;
    logic [7:0] o;
    logic cy, e;
    o = 8'h00; cy = 1'b0; e = 1'b0;
    case (c)
      4'd0: begin s = int'(x) + int'(y); o = 8'(s % 256); cy = (s > 255); end
      4'd1: begin s = int'(x) - int'(y); o = 8'((s + 256) % 256); cy = (int'(x) < int'(y)); end
      4'd2: o = x & y;
      4'd3: o = x | y;
      4'd4: o = ~x;
      4'd5: o = x ^ y;
      4'd6: o = ~(x | y);
      4'd7: o = 8'((int'(y) * (1 << int'(x[2:0]))) % 256);
      4'd8: o = 8'(int'(y) / (1 << int'(x[2:0])));
      4'd9: o = 8'(int'(x) / 2 + (x[7] ? 128 : 0));
      default: e = 1'b1;
    endcase
    return {e, cy, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; r_ready = 1'b0;
    a_ctrl = 4'd0; a_x = 8'h00; a_y = 8'h00;
    b_ctrl = 4'd0; b_x = 8'h00; b_y = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    exp_last_b = 1'b1;
  endtask

  // Drives one isolated operation; lat = edges after the accept edge until r_valid (-1 on timeout)
  task automatic do_op(input logic sel_b, input logic [3:0] c, input logic [7:0] xx, input logic [7:0] yy,
                       output logic [7:0] o, output logic cy, output logic er, output logic sr,
                       output int lat);
    int n;
    a_valid = 1'b0; b_valid = 1'b0; r_ready = 1'b0;
    if (sel_b) begin b_valid = 1'b1; b_ctrl = c; b_x = xx; b_y = yy; end
    else       begin a_valid = 1'b1; a_ctrl = c; a_x = xx; a_y = yy; end
    #1;
    n = 0;
    while (!(sel_b ? b_ready : a_ready) && n < 20) begin tick(); n++; end
    lat = -1; o = 8'h00; cy = 1'b0; er = 1'b0; sr = 1'b0;
    if (n < 20) begin
      exp_last_b = sel_b;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      a_x = 8'($urandom); a_y = 8'($urandom); a_ctrl = 4'($urandom);
      b_x = 8'($urandom); b_y = 8'($urandom); b_ctrl = 4'($urandom);
      lat = 0;
      while (!r_valid && lat < 20) begin tick(); lat++; end
      if (lat >= 20) lat = -1;
      o = r_out; cy = r_carry; er = r_err; sr = r_src;
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({r_valid, r_out, r_carry, r_src, r_err, r_count} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b out=%h c=%0b src=%0b err=%0b cnt=%0d, want all zero",
               r_valid, r_out, r_carry, r_src, r_err, r_count);
    end
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_tie: got a_ready=%0b b_ready=%0b, want 1 0", a_ready, b_ready);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] o; logic cy, er, sr; int lat;
    apply_reset();
    do_op(1'b0, 4'd0, 8'hFF, 8'h18, o, cy, er, sr, lat);
    checks++;
    if ({o, cy, sr, er} !== {8'h17, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_carry: got out=%h c=%0b src=%0b err=%0b, want 17 1 0 0", o, cy, sr, er);
    end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL latency: got %0d extra edges, want 1", lat); end
    checks++;
    if (r_count !== 8'd1) begin errors++; $display("FAIL count_first: got %0d, want 1", r_count); end
    do_op(1'b0, 4'd1, 8'h05, 8'h0A, o, cy, er, sr, lat);
    checks++;
    if ({o, cy} !== {8'hFB, 1'b1}) begin
      errors++; $display("FAIL sub_borrow: got out=%h c=%0b, want FB 1", o, cy);
    end
    do_op(1'b0, 4'd7, 8'h0A, 8'h05, o, cy, er, sr, lat);
    checks++;
    if ({o, cy} !== {8'h14, 1'b0}) begin
      errors++; $display("FAIL shl: got out=%h c=%0b, want 14 0", o, cy);
    end
    do_op(1'b0, 4'd9, 8'h8A, 8'($urandom), o, cy, er, sr, lat);
    checks++;
    if ({o, cy} !== {8'hC5, 1'b0}) begin
      errors++; $display("FAIL asr: got out=%h c=%0b, want C5 0", o, cy);
    end
    checks++;
    if (r_count !== 8'd4) begin errors++; $display("FAIL count_four: got %0d, want 4", r_count); end
  endtask

  task automatic test_round_robin();
    logic [10:0] q[$];
    logic [10:0] e;
    logic        win_b;
    int          j = 0;
    apply_reset();
    a_valid = 1'b1; b_valid = 1'b1; r_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_ctrl = 4'($urandom); a_x = 8'($urandom); a_y = 8'($urandom);
      b_ctrl = 4'($urandom); b_x = 8'($urandom); b_y = 8'($urandom);
      #1;
      checks++;
      if (a_ready && b_ready) begin errors++; $display("FAIL rr_both_ready: cycle %0d", i); end
      if (a_ready || b_ready) begin
        win_b = ~exp_last_b;
        checks++;
        if (b_ready !== win_b) begin
          errors++; $display("FAIL rr_grant: cycle %0d got b_ready=%0b, want %0b", i, b_ready, win_b);
        end
        q.push_back(win_b ? {1'b1, ref_alu(b_ctrl, b_x, b_y)} : {1'b0, ref_alu(a_ctrl, a_x, a_y)});
        exp_last_b = win_b;
      end
      tick();
      checks++;
      if (r_valid !== 1'((i % 2) == 1)) begin
        errors++; $display("FAIL rr_rate: cycle %0d got r_valid=%0b, want %0b", i, r_valid, (i % 2) == 1);
      end
      if (r_valid && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({r_src, r_err, r_carry, r_out} !== e || r_src !== 1'(j % 2)) begin
          errors++;
          $display("FAIL rr_result %0d: got src=%0b err=%0b c=%0b out=%h, want src=%0b err=%0b c=%0b out=%h",
                   j, r_src, r_err, r_carry, r_out, e[10], e[9], e[8], e[7:0]);
        end
        j++;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0; r_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [9:0] e1, e2;
    apply_reset();
    b_ctrl = 4'($urandom_range(9, 0)); b_x = 8'($urandom); b_y = 8'($urandom);
    e1 = ref_alu(b_ctrl, b_x, b_y);
    b_valid = 1'b1;
    #1;
    checks++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready: got %0b, want 1", b_ready); end
    tick();
    b_ctrl = 4'($urandom_range(9, 0)); b_x = 8'($urandom); b_y = 8'($urandom);
    e2 = ref_alu(b_ctrl, b_x, b_y);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({r_valid, r_src, r_err, r_carry, r_out, b_ready, r_count} !== {1'b1, 1'b1, e1, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got v=%0b src=%0b err=%0b c=%0b out=%h b_ready=%0b cnt=%0d, want 1 1 %0b %0b %h 0 0",
                 i, r_valid, r_src, r_err, r_carry, r_out, b_ready, r_count, e1[9], e1[8], e1[7:0]);
      end
      tick();
    end
    r_ready = 1'b1;
    #1;
    checks++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b, want 1", b_ready); end
    tick();
    r_ready = 1'b0; b_valid = 1'b0;
    checks++;
    if ({r_valid, r_count} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL bp_release_count: got v=%0b cnt=%0d, want 0 1", r_valid, r_count);
    end
    tick();
    checks++;
    if ({r_valid, r_src, r_err, r_carry, r_out} !== {1'b1, 1'b1, e2}) begin
      errors++;
      $display("FAIL bp_second: got v=%0b src=%0b err=%0b c=%0b out=%h, want 1 1 %0b %0b %h",
               r_valid, r_src, r_err, r_carry, r_out, e2[9], e2[8], e2[7:0]);
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    checks++;
    if (r_count !== 8'd2) begin errors++; $display("FAIL bp_final_count: got %0d, want 2", r_count); end
  endtask

  task automatic test_illegal();
    logic [7:0] o; logic cy, er, sr; int lat;
    logic [3:0] c; logic [7:0] x, y; logic [9:0] e;
    apply_reset();
    do_op(1'b1, 4'hC, 8'($urandom), 8'($urandom), o, cy, er, sr, lat);
    checks++;
    if ({er, o, cy, sr} !== {1'b1, 8'h00, 1'b0, 1'b1} || lat !== 1) begin
      errors++; $display("FAIL illegal_c: got err=%0b out=%h c=%0b src=%0b lat=%0d, want 1 00 0 1 1", er, o, cy, sr, lat);
    end
    c = 4'($urandom_range(9, 0)); x = 8'($urandom); y = 8'($urandom);
    e = ref_alu(c, x, y);
    do_op(1'b1, c, x, y, o, cy, er, sr, lat);
    checks++;
    if ({er, cy, o} !== e || e[9] !== 1'b0) begin
      errors++; $display("FAIL legal_after_illegal: ctrl=%0d got err=%0b c=%0b out=%h, want %0b %0b %h",
                         c, er, cy, o, e[9], e[8], e[7:0]);
    end
    c = 4'($urandom_range(15, 10));
    do_op(1'b0, c, 8'($urandom), 8'($urandom), o, cy, er, sr, lat);
    checks++;
    if ({er, o, cy, sr} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL illegal_a: ctrl=%0d got err=%0b out=%h c=%0b src=%0b, want 1 00 0 0", c, er, o, cy, sr);
    end
    checks++;
    if (r_count !== 8'd3) begin errors++; $display("FAIL illegal_count: got %0d, want 3", r_count); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    a_valid = 1'b1; a_ctrl = 4'd0; a_x = 8'hFF; a_y = 8'hFF;
    #1;
    tick();
    a_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({r_valid, r_out, r_carry, r_src, r_err, r_count} !== 20'h0) begin
      errors++; $display("FAIL reset_in_exec: got v=%0b out=%h c=%0b cnt=%0d, want zeros", r_valid, r_out, r_carry, r_count);
    end
    tick();
    checks++;
    if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_in_exec_late: got r_valid=%0b, want 0", r_valid); end
    a_valid = 1'b1; a_ctrl = 4'd4; a_x = 8'h00;
    #1;
    tick();
    a_valid = 1'b0;
    tick();
    checks++;
    if ({r_valid, r_out} !== {1'b1, 8'hFF}) begin
      errors++; $display("FAIL pre_reset_resp: got v=%0b out=%h, want 1 FF", r_valid, r_out);
    end
    r_ready = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; r_ready = 1'b0;
    checks++;
    if ({r_valid, r_out, r_carry, r_src, r_err, r_count} !== 20'h0) begin
      errors++; $display("FAIL reset_in_resp: got v=%0b out=%h cnt=%0d, want zeros", r_valid, r_out, r_count);
    end
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++; $display("FAIL reset_tie_after_a: got a_ready=%0b b_ready=%0b, want 1 0", a_ready, b_ready);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    exp_last_b = 1'b1;
  endtask

  task automatic test_random_wrap();
    logic [10:0] q[$];
    logic [10:0] e;
    logic        win_a, win_b;
    int          done = 0;
    int          cyc = 0;
    apply_reset();
    while (done < 256 && cyc < 4000) begin
      a_valid = 1'($urandom_range(3, 0) != 0); b_valid = 1'($urandom_range(1, 0));
      r_ready = 1'($urandom_range(3, 0) != 0);
      a_ctrl = 4'($urandom); a_x = 8'($urandom); a_y = 8'($urandom);
      b_ctrl = 4'($urandom); b_x = 8'($urandom); b_y = 8'($urandom);
      #1;
      win_b = b_valid & (~a_valid | ~exp_last_b);
      win_a = a_valid & ~win_b;
      checks++;
      if ((a_ready && !win_a) || (b_ready && !win_b)) begin
        errors++; $display("FAIL rand_grant cyc %0d: got a_ready=%0b b_ready=%0b, want winner a=%0b b=%0b",
                           cyc, a_ready, b_ready, win_a, win_b);
      end
      if (a_ready || b_ready) begin
        q.push_back(b_ready ? {1'b1, ref_alu(b_ctrl, b_x, b_y)} : {1'b0, ref_alu(a_ctrl, a_x, a_y)});
        exp_last_b = b_ready;
      end
      if (r_valid && r_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious: result with no pending op at cyc %0d", cyc);
        end else begin
          e = q.pop_front();
          if ({r_src, r_err, r_carry, r_out} !== e || r_count !== 8'(done)) begin
            errors++;
            $display("FAIL rand_result %0d: got src=%0b err=%0b c=%0b out=%h cnt=%0d, want %0b %0b %0b %h %0d",
                     done, r_src, r_err, r_carry, r_out, r_count, e[10], e[9], e[8], e[7:0], done % 256);
          end
        end
        done++;
      end
      tick();
      cyc++;
    end
    a_valid = 1'b0; b_valid = 1'b0; r_ready = 1'b0;
    checks++;
    if (done < 256) begin errors++; $display("FAIL rand_timeout: only %0d of 256 results", done); end
    checks++;
    if (r_count !== 8'd0) begin errors++; $display("FAIL count_wrap: got %0d, want 0", r_count); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
